// File: rtl/lcd_arbiter.sv
// Round-robin arbiter granting two clients exclusive use of the LCD character
// write port, followed by one refresh handshake per grant and a hold watchdog.
module lcd_arbiter #(
   parameter int MAX_HOLD   = 1024,
   parameter int HOLD_WIDTH = 11
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       a_req,
   input  logic       b_req,
   output logic       a_gnt,
   output logic       b_gnt,
   input  logic       a_row,
   input  logic       b_row,
   input  logic [3:0] a_col,
   input  logic [3:0] b_col,
   input  logic [7:0] a_char,
   input  logic [7:0] b_char,
   input  logic       a_we,
   input  logic       b_we,
   input  logic       a_done,
   input  logic       b_done,
   output logic       lcd_row,
   output logic [3:0] lcd_col,
   output logic [7:0] lcd_char,
   output logic       lcd_we,
   output logic       lcd_update,
   input  logic       lcd_busy,
   output logic       hold_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_UPDATE,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   localparam logic OWN_B = 1'b1;
   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_own;
   logic                  r_last;
   logic                  r_timeout;
   logic [HOLD_WIDTH-1:0] r_hold;

   logic w_own_req;
   logic w_own_done;
   logic w_hold_expired;
   logic w_release;
   logic w_watchdog;
   logic w_grant;
   logic w_pick;

   always_comb begin
      w_own_req      = (r_own == OWN_B) ? b_req  : a_req;
      w_own_done     = (r_own == OWN_B) ? b_done : a_done;
      w_hold_expired = (r_hold == HOLD_LAST);
      w_release      = w_own_done || !w_own_req || w_hold_expired;
      // A voluntary release in the final cycle is not a watchdog event.
      w_watchdog     = w_hold_expired && w_own_req && !w_own_done;
      w_pick         = (a_req && b_req) ? ~r_last : b_req;
   end

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (a_req || b_req) begin
               w_grant      = 1'b1;
               w_next_state = S_GRANT;
            end
         end
         S_GRANT:   if (w_release) w_next_state = S_UPDATE;
         S_UPDATE:  if (!lcd_busy) w_next_state = S_WAIT_HI;
         S_WAIT_HI: if (lcd_busy)  w_next_state = S_WAIT_LO;
         S_WAIT_LO: if (!lcd_busy) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_own     <= 1'b0;
         r_last    <= OWN_B;
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_timeout <= (r_state == S_GRANT) && w_watchdog;
         if (w_grant) begin
            r_own  <= w_pick;
            r_hold <= '0;
         end else if (r_state == S_GRANT) begin
            if (!w_hold_expired) r_hold <= r_hold + 1'b1;
            if (w_release)       r_last <= r_own;
         end
      end
   end

   // Outputs decode registered state, so an asynchronous reset clears them at once.
   always_comb begin
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      lcd_row  = 1'b0;
      lcd_col  = '0;
      lcd_char = '0;
      lcd_we   = 1'b0;
      if (r_state == S_GRANT) begin
         a_gnt = (r_own != OWN_B);
         b_gnt = (r_own == OWN_B);
         if (r_own == OWN_B) begin
            lcd_row  = b_row;
            lcd_col  = b_col;
            lcd_char = b_char;
            lcd_we   = b_we;
         end else begin
            lcd_row  = a_row;
            lcd_col  = a_col;
            lcd_char = a_char;
            lcd_we   = a_we;
         end
      end
   end

   assign lcd_update   = (r_state == S_UPDATE) && !lcd_busy;
   assign hold_timeout = r_timeout;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: expected writes and grant order are queued
// at stimulus time and compared as the DUT presents them.
module tb_lcd_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       a_req, b_req, a_gnt, b_gnt;
   logic       a_row, b_row;
   logic [3:0] a_col, b_col;
   logic [7:0] a_char, b_char;
   logic       a_we, b_we, a_done, b_done;
   logic       lcd_row;
   logic [3:0] lcd_col;
   logic [7:0] lcd_char;
   logic       lcd_we, lcd_update, lcd_busy, hold_timeout;

   logic       m_busy;
   logic [2:0] m_cnt;
   logic       force_busy;

   int total = 0;
   int bad   = 0;
   int upd_cnt = 0;
   int tmo_cnt = 0;
   int we_cnt  = 0;

   logic [12:0] wr_q[$];
   logic        gnt_q[$];

   lcd_arbiter #(.MAX_HOLD(16), .HOLD_WIDTH(5)) dut (
      .CLK(CLK), .RST(RST),
      .a_req(a_req), .b_req(b_req), .a_gnt(a_gnt), .b_gnt(b_gnt),
      .a_row(a_row), .b_row(b_row), .a_col(a_col), .b_col(b_col),
      .a_char(a_char), .b_char(b_char), .a_we(a_we), .b_we(b_we),
      .a_done(a_done), .b_done(b_done),
      .lcd_row(lcd_row), .lcd_col(lcd_col), .lcd_char(lcd_char),
      .lcd_we(lcd_we), .lcd_update(lcd_update), .lcd_busy(lcd_busy),
      .hold_timeout(hold_timeout)
   );

   always #5 CLK = ~CLK;

   // LCD controller model: busy rises the edge after update, lasts 4 cycles.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_busy <= 1'b0;
         m_cnt  <= '0;
      end else if (!m_busy && lcd_update) begin
         m_busy <= 1'b1;
         m_cnt  <= 3'd3;
      end else if (m_busy) begin
         if (m_cnt == 0) m_busy <= 1'b0;
         else            m_cnt  <= m_cnt - 1'b1;
      end
   end
   assign lcd_busy = m_busy | force_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         check("one_hot_gnt", 32'(a_gnt & b_gnt), 0);
         if (lcd_update)   upd_cnt++;
         if (hold_timeout) tmo_cnt++;
         if (lcd_we) begin
            we_cnt++;
            if (wr_q.size() == 0) check("wr_extra", 1, 0);
            else check("wr_data", 32'({lcd_row, lcd_col, lcd_char}), 32'(wr_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      RST = 1'b0;
      {a_req, b_req, a_row, b_row, a_we, b_we, a_done, b_done} = '0;
      a_col = '0; b_col = '0; a_char = '0; b_char = '0;
      force_busy = 1'b0;
      wr_q.delete();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
   endtask

   task automatic put_char(input logic who, input logic row, input logic [3:0] col,
                           input logic [7:0] ch);
      if (who) begin b_we = 1; b_row = row; b_col = col; b_char = ch; end
      else     begin a_we = 1; a_row = row; a_col = col; a_char = ch; end
      wr_q.push_back({row, col, ch});
      tick();
      a_we = 0;
      b_we = 0;
   endtask

   task automatic pulse_done(input logic who);
      if (who) b_done = 1; else a_done = 1;
      tick();
      a_done = 0;
      b_done = 0;
   endtask

   task automatic wait_gnt();
      int n = 0;
      while (!(a_gnt || b_gnt) && n < 300) begin tick(); n++; end
      check("gnt_bound", 32'(n >= 300), 0);
   endtask

   // Waits for the refresh to start and finish, then for the return to idle.
   task automatic wait_refresh();
      int n = 0;
      while (!lcd_busy && n < 200) begin tick(); n++; end
      while (lcd_busy && n < 400) begin tick(); n++; end
      check("refresh_bound", 32'(n >= 400), 0);
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 32'({a_gnt, b_gnt, lcd_we, lcd_update, hold_timeout,
                      lcd_row, lcd_col, lcd_char}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int u0, w0, t0, hold;
      logic who;

      // Single client A
      reset_dut();
      check_all_zero("reset_outputs");
      a_req = 1;
      #1 check("gnt_not_early", a_gnt, 0);
      tick();
      check("req_to_gnt", a_gnt, 1);
      u0 = upd_cnt; w0 = we_cnt;
      for (int i = 0; i < 4; i++) put_char(0, 0, 4'(i), 8'h41 + 8'(i));
      pulse_done(0);
      a_req = 0;
      check("done_drop_gnt", a_gnt, 0);
      wait_refresh();
      check("single_we_count", 32'(we_cnt - w0), 4);
      check("single_upd_count", 32'(upd_cnt - u0), 1);
      a_req = 1;
      tick();
      check("idle_regrant", a_gnt, 1);
      pulse_done(0);
      a_req = 0;
      wait_refresh();

      // Tie from reset: A, B, A, B
      reset_dut();
      a_req = 1; b_req = 1;
      gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      u0 = upd_cnt;
      for (int k = 0; k < 4; k++) begin
         wait_gnt();
         who = b_gnt;
         check("tie_order", 32'(who), 32'(gnt_q.pop_front()));
         if (k > 0) check("tie_upd_between", 32'(upd_cnt - u0), 1);
         u0 = upd_cnt;
         put_char(who, who, 4'(2 * k), 8'h61 + 8'(k));
         put_char(who, who, 4'(2 * k + 1), 8'h71 + 8'(k));
         pulse_done(who);
      end
      a_req = 0; b_req = 0;
      wait_refresh();

      // Update held off by busy; write in the same cycle as done still lands
      reset_dut();
      a_req = 1;
      tick();
      a_we = 1; a_row = 1; a_col = 4'd5; a_char = 8'h5A;
      wr_q.push_back({1'b1, 4'd5, 8'h5A});
      a_done = 1;
      force_busy = 1;
      tick();
      a_we = 0; a_done = 0; a_req = 0;
      check("busy_done_drop", a_gnt, 0);
      u0 = upd_cnt;
      repeat (50) begin
         @(negedge CLK);
         check("upd_blocked", lcd_update, 0);
      end
      tick();
      force_busy = 0;
      #1 check("upd_after_busy", lcd_update, 1);
      wait_refresh();
      check("busy_upd_count", 32'(upd_cnt - u0), 1);

      // Watchdog with MAX_HOLD=16
      reset_dut();
      t0 = tmo_cnt;
      a_req = 1;
      tick();
      b_req = 1;
      hold = 0;
      while (a_gnt && hold < 100) begin hold++; tick(); end
      check("wd_hold_cycles", 32'(hold), 16);
      check("wd_timeout_pulse", hold_timeout, 1);
      tick();
      check("wd_timeout_clear", hold_timeout, 0);
      a_req = 0;
      wait_gnt();
      check("wd_b_granted", b_gnt, 1);
      pulse_done(1);
      b_req = 0;
      wait_refresh();
      check("wd_timeout_count", 32'(tmo_cnt - t0), 1);

      // Non-owner isolation
      reset_dut();
      a_req = 1;
      tick();
      b_req = 1; b_we = 1; b_done = 1; b_row = 1; b_col = 4'hF; b_char = 8'hEE;
      #1 check("iso_we_blocked", lcd_we, 0);
      a_we = 1; a_row = 1; a_col = 4'd2; a_char = 8'h33;
      wr_q.push_back({1'b1, 4'd2, 8'h33});
      #1 check("iso_we_owner", lcd_we, 1);
      tick();
      check("iso_keep_gnt", a_gnt, 1);
      a_we = 0; b_we = 0; b_done = 0; b_req = 0;
      pulse_done(0);
      a_req = 0;
      wait_refresh();

      // Reset mid-grant
      reset_dut();
      b_req = 1;
      tick();
      check("rst_b_gnt", b_gnt, 1);
      put_char(1, 1, 4'd7, 8'h62);
      u0 = upd_cnt;
      RST = 0;
      #1 check_all_zero("rst_mid_outputs");
      b_req = 0;
      repeat (3) @(posedge CLK);
      #1 RST = 1;
      repeat (20) tick();
      check("rst_no_update", 32'(upd_cnt - u0), 0);
      a_req = 1; b_req = 1;
      tick();
      check("rst_tie_a", 32'({a_gnt, b_gnt}), 32'(2'b10));
      b_req = 0;
      pulse_done(0);
      a_req = 0;
      wait_refresh();

      check("wr_queue_empty", 32'(wr_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
